serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
//
// PURPOSE
//   Bit-serial subtractor, the inverse arithmetic of the ripple full_adder path.
//   Computes diff = a - b - borrow_in, LSB first, using one full-subtractor cell per clock.
//   Operands enter and results leave through valid/ready handshakes.
//   It sits beside the adder blocks as the area-cheap subtract unit.
//
// PARAMETERS
//   WIDTH        8   operand/result width in bits (>= 2)
//
// PORTS
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous active-low reset
//   in_valid    in   1       operands a/b/borrow_in are valid
//   in_ready    out  1       block can accept an operation
//   a           in   WIDTH   minuend
//   b           in   WIDTH   subtrahend
//   borrow_in   in   1       initial borrow
//   out_valid   out  1       diff/borrow_out are valid
//   out_ready   in   1       consumer accepts the result
//   diff        out  WIDTH   (a - b - borrow_in) mod 2^WIDTH
//   borrow_out  out  1       1 when a < b + borrow_in (unsigned)
//   busy        out  1       state != IDLE
//
// BEHAVIOUR
// - Reset:
//   - Asynchronous, active low. rst_n low forces state=IDLE, bit counter=0,
//     shift registers=0, diff=0, borrow_out=0, out_valid=0, busy=0.
//   - in_ready = (state==IDLE), so it reads 1 while in reset. No transfer completes while rst_n is low.
//   - Asserting reset mid-operation aborts the operation. No result is produced.
// - FSM states:
//   - IDLE: in_ready=1. in_valid&&in_ready latches a, b, borrow_in, clears the counter, and moves to SHIFT.
//   - SHIFT: each clock processes bit i = counter[0 .. WIDTH-1]:
//     - d_i   = a_i ^ b_i ^ br
//     - br'   = (~a_i & b_i) | (~(a_i ^ b_i) & br)
//     - d_i shifts in at the diff MSB; the operand registers shift right; counter increments.
//     - On the edge that processes bit WIDTH-1, load borrow_out=br' and move to DONE.
//   - DONE: out_valid=1. diff and borrow_out are held stable until out_valid&&out_ready; then go to IDLE.
// - Timing and throughput:
//   - Latency: accept on edge E0; out_valid is high after edge E_WIDTH (WIDTH cycles).
//   - Throughput: one operation per WIDTH+2 cycles minimum. in_ready=0 in SHIFT and DONE; no overlap.
// - Signal rules:
//   - in_valid, a, b, borrow_in are ignored outside IDLE. Operand changes after acceptance have no effect.
//   - out_ready is ignored when out_valid=0. It may be held high permanently.
//   - out_valid, in_ready and busy depend only on state; there is no combinational path from in_* to out_*.
//   - After a completed handshake, diff/borrow_out keep their last value but are meaningful only while out_valid=1.
//   - The counter is $clog2(WIDTH)+1 bits and has no wrap-around inside one operation.
//
// TESTING (WIDTH=8 unless noted)
// 1. a=0x05,b=0x03,bin=0 -> diff=0x02, borrow_out=0; out_valid exactly 8 cycles after accept.
// 2. a=0x03,b=0x05,bin=0 -> diff=0xFE, borrow_out=1; a=0x00,b=0x00,bin=1 -> diff=0xFF, borrow_out=1.
// 3. a=0xFF,b=0xFF,bin=0 -> diff=0x00, borrow_out=0; a=0x80,b=0x01,bin=0 -> diff=0x7F, borrow_out=0.
// 4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid,diff,borrow_out stable; in_ready=0;
//    a new in_valid is not accepted until the cycle after the out handshake.
// 5. rst_n pulsed low after bit 3 -> out_valid=0, busy=0, in_ready=1 immediately;
//    next op a=0x10,b=0x01 -> diff=0x0F.
// 6. WIDTH=4 exhaustive: all 512 (a,b,bin) vs model {borrow_out,diff} = a - b - bin (5-bit two's complement).

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor.
// Computes diff = a - b - borrow_in one bit per clock, LSB first, through a
// single full-subtractor cell. Operands are taken and the result is returned
// through valid/ready handshakes. Only one operation is in flight at a time.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    // The counter has one extra bit so it cannot wrap while stepping through WIDTH bits.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [CW-1:0]    cnt_reg;
    logic             br_reg;
    logic             borrow_out_reg;
    logic             out_valid_reg;
    logic             in_ready_reg;
    logic             busy_reg;

    // Full-subtractor cell acting on the current LSB of the operand shifters.
    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic br_next;
    logic last_bit;

    assign a_bit    = a_sh_reg[0];
    assign b_bit    = b_sh_reg[0];
    assign d_bit    = a_bit ^ b_bit ^ br_reg;
    assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // Status outputs come straight from registers, so none of them combinationally depends on in_*.
    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign busy       = busy_reg;
    assign diff       = diff_reg;
    assign borrow_out = borrow_out_reg;

    // Control FSM and datapath: accept, shift one bit per clock, hold the result until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            a_sh_reg       <= '0;
            b_sh_reg       <= '0;
            diff_reg       <= '0;
            cnt_reg        <= '0;
            br_reg         <= 1'b0;
            borrow_out_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            in_ready_reg   <= 1'b1;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg     <= a;
                        b_sh_reg     <= b;
                        br_reg       <= borrow_in;
                        cnt_reg      <= '0;
                        state_reg    <= SHIFT;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                SHIFT: begin
                    // The new difference bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
                    a_sh_reg <= a_sh_reg >> 1;
                    b_sh_reg <= b_sh_reg >> 1;
                    diff_reg <= {d_bit, diff_reg[WIDTH-1:1]};
                    br_reg   <= br_next;
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        borrow_out_reg <= br_next;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed vectors, backpressure and reset
// corner cases, random operands against an arithmetic model (WIDTH=8), and an
// exhaustive sweep on a WIDTH=4 instance.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       iv8, ir8, bin8, ov8, or8, bo8, busy8;
    logic [7:0] a8, b8, d8;
    // WIDTH=4 instance
    logic       iv4, ir4, bin4, ov4, or4, bo4, busy4;
    logic [3:0] a4, b4, d4;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .borrow_in(bin8), .out_valid(ov8), .out_ready(or8), .diff(d8),
        .borrow_out(bo8), .busy(busy8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .borrow_in(bin4), .out_valid(ov4), .out_ready(or4), .diff(d4),
        .borrow_out(bo4), .busy(busy4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // One full transaction on the 8-bit instance; starts and ends 1 ns after a rising edge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bo, output int lat);
        int k;
        a8 = a; b8 = b; bin8 = bin; iv8 = 1'b1;
        k = 0;
        while (!ir8 && k < 50) begin @(posedge clk); #1; k++; end
        if (!ir8) chk("op8_accept_timeout", 32'(ir8), 32'd1);
        @(posedge clk); #1;
        // Scramble operands after acceptance: they must have no effect.
        iv8 = 1'b0; a8 = ~a; b8 = ~b; bin8 = ~bin;
        lat = 0;
        while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
        d = d8; bo = bo8;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                       output logic [3:0] d, output logic bo, output int lat);
        int k;
        a4 = a; b4 = b; bin4 = bin; iv4 = 1'b1;
        k = 0;
        while (!ir4 && k < 50) begin @(posedge clk); #1; k++; end
        if (!ir4) chk("op4_accept_timeout", 32'(ir4), 32'd1);
        @(posedge clk); #1;
        iv4 = 1'b0; a4 = ~a; b4 = ~b; bin4 = ~bin;
        lat = 0;
        while (!ov4 && lat < 50) begin @(posedge clk); #1; lat++; end
        d = d4; bo = bo4;
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [7:0] d;
        logic       bo;
        logic [3:0] dd;
        logic       bb;
        logic [8:0] r9;
        logic [4:0] r5;
        int         lat;

        iv8 = 0; or8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        iv4 = 0; or4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        rst_n = 1'b0;

        vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bo: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, d: 8'hFE, bo: 1'b1};
        vecs[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bo: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, bin: 1'b0, d: 8'h00, bo: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bo: 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ir8), 32'd1);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_diff", 32'(d8), 32'd0);
        chk("rst_borrow", 32'(bo8), 32'd0);
        chk("rst4_in_ready", 32'(ir4), 32'd1);
        rst_n = 1'b1;

        // Directed vectors with latency check
        for (int i = 0; i < 5; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, lat);
            chk($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].d));
            chk($sformatf("vec%0d_borrow", i), 32'(bo), 32'(vecs[i].bo));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
        end

        // Backpressure: 0x5A-0x33-1 = 0x26, held 5 cycles; a second request waits.
        a8 = 8'h5A; b8 = 8'h33; bin8 = 1'b1; iv8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h01; b8 = 8'h02; bin8 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(ov8), 32'd1);
            chk("bp_diff", 32'(d8), 32'h26);
            chk("bp_borrow", 32'(bo8), 32'd0);
            chk("bp_in_ready", 32'(ir8), 32'd0);
            @(posedge clk); #1;
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk("bp_post_hs_out_valid", 32'(ov8), 32'd0);
        chk("bp_post_hs_in_ready", 32'(ir8), 32'd1);
        chk("bp_post_hs_busy", 32'(busy8), 32'd0);
        @(posedge clk); #1;
        iv8 = 1'b0;
        chk("bp_second_accept_busy", 32'(busy8), 32'd1);
        chk("bp_second_accept_in_ready", 32'(ir8), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("bp_second_out_valid", 32'(ov8), 32'd1);
        chk("bp_second_diff", 32'(d8), 32'hFF);
        chk("bp_second_borrow", 32'(bo8), 32'd1);
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;

        // Reset after bit 3 aborts the operation
        a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(ov8), 32'd0);
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_in_ready", 32'(ir8), 32'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'h10, 8'h01, 1'b0, d, bo, lat);
        chk("after_abort_diff", 32'(d), 32'h0F);
        chk("after_abort_borrow", 32'(bo), 32'd0);
        chk("after_abort_latency", 32'(lat), 32'd8);

        // Random operands against arithmetic model
        for (int i = 0; i < 150; i++) begin
            logic [7:0] ra, rb;
            logic       rbin;
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            r9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            op8(ra, rb, rbin, d, bo, lat);
            chk($sformatf("rnd%0d_diff a=%0h b=%0h bin=%0d", i, ra, rb, rbin), 32'(d), 32'(r9[7:0]));
            chk($sformatf("rnd%0d_borrow", i), 32'(bo), 32'(r9[8]));
        end

        // WIDTH=4 exhaustive
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    r5 = 5'(ia) - 5'(ib) - 5'(ic);
                    op4(4'(ia), 4'(ib), 1'(ic), dd, bb, lat);
                    chk($sformatf("w4 a=%0h b=%0h bin=%0d", ia, ib, ic), 32'({bb, dd}), 32'(r5));
                end
            end
        end
        chk("w4_latency", 32'(lat), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
